spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
- Consumes the byte stream from the SPI slave front end (byte_received / byte_data_received) and supplies its transmit data (byte_send / send_latch).
- Decodes a command/data framing protocol into an 8 x 8-bit register file shared with the CoCo-side bus interface.
- Raises a mailbox interrupt to the CoCo when the SPI master writes register 0.

Parameters:
- NREGS, 8, number of registers; fixed at 8, so addresses are 3 bits.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  in  1  system clock, same clock as the SPI slave.
- reset_n  in  1  asynchronous reset, active-low.
- ssel  in  1  raw SPI chip select, active-low, asynchronous to clk.
- byte_received  in  1  one-clk pulse: a byte has been received from the SPI slave.
- byte_data_received  in  8  received byte; valid when byte_received is high.
- byte_send  out  8  next byte for the SPI slave to transmit.
- send_latch  out  1  high while byte_send is valid for loading into the SPI slave.
- host_addr  in  3  CoCo-side register address.
- host_we  in  1  CoCo-side write strobe, one clk.
- host_re  in  1  CoCo-side read strobe, one clk.
- host_wdata  in  8  CoCo-side write data.
- host_rdata  out  8  reg[host_addr], combinational read.
- irq_n  out  1  mailbox interrupt to the CoCo, active-low.
- frame_err  out  1  sticky flag: a bad command byte was seen.

Behaviour:
- Reset (async, reset_n low):
  - All registers = RESET_VAL; state = IDLE; addr_ptr = 0.
  - byte_send = 8'h00; send_latch = 0; irq_n = 1; frame_err = 0.
- ssel synchronization:
  - ssel passes through a 3-flop synchronizer; active = ~ssel_s[1].
  - Whenever active is low, state goes to IDLE in the next clk, regardless of current state.
  - send_latch is 0 whenever active is low.
- Command byte: the first byte of a frame.
  - Bit 7 = R (1 = read).
  - Bit 6 = AI (auto-increment).
  - Bits 5:3 must be 000.
  - Bits 2:0 = start address.
- State machine:
  - IDLE: when active is high, go to CMD.
  - CMD, on byte_received:
    - Bits 5:3 != 0: go to IGNORE and set frame_err.
    - Otherwise latch addr_ptr = bits 2:0 and AI.
    - R = 1: go to RD. R = 0: go to WR.
  - WR, on each byte_received:
    - reg[addr_ptr] <= byte_data_received.
    - If AI, addr_ptr <= addr_ptr + 1, wrapping mod 8 (7 -> 0).
  - RD:
    - send_latch = 1 and byte_send = reg[addr_ptr] (registered), valid from 1 clk after the CMD byte_received.
    - On each byte_received, advance addr_ptr if AI, then byte_send updates 1 clk later.
    - With AI = 0, the same register is re-sent on every byte.
  - IGNORE: all bytes are discarded; send_latch = 0 and byte_send = 8'h00 until ssel deasserts.
- Timing: response latency is 1 clk after byte_received. The SCK half-period must be at least 4 clk so the SPI slave loads byte_send before its first shift falling edge.
- Host port:
  - host_we writes reg[host_addr] <= host_wdata.
  - If an SPI write and a host write hit the same register in the same clk, the SPI write wins and the host write is dropped.
  - Writes to different registers in the same clk both complete.
  - In RD, byte_send reflects the register value present at the clk it is registered.
- Mailbox:
  - irq_n goes to 0 one clk after an SPI write to reg 0.
  - irq_n returns to 1 one clk after host_re with host_addr = 0.
  - If host_re of reg 0 and an SPI write of reg 0 occur in the same clk, irq_n stays 0 (set wins).
  - Host writes to reg 0 do not affect irq_n.
- frame_err is sticky. It is cleared only by reset_n, or by a host write of any value to reg 7 with host_wdata[7] = 1; in that case reg 7 is still written normally.
- Reset mid-frame: everything returns to reset values; the SPI-side state stays IDLE until the next ssel deassert -> assert cycle is seen.

Test Plan:
- Write burst: ssel low; bytes 8'h42 (W, AI, addr 2), then 8'hA1, 8'hB2 -> reg2 = A1, reg3 = B2; irq_n stays 1.
- Wrap-around: command 8'h47, data 11, 22 -> reg7 = 11, reg0 = 22; irq_n goes 0 one clk after the second byte_received; host_re at addr 0 -> irq_n = 1 the next clk.
- Read with AI: reg5 = 5A, reg6 = 6B; command 8'hC5 -> one clk later send_latch = 1 and byte_send = 5A; after the next byte_received, byte_send = 6B; ssel high -> send_latch = 0 within 4 clk.
- Read without AI: command 8'h83 with reg3 = 77, three dummy bytes -> byte_send stays 77 throughout.
- Bad command: 8'h28 followed by 8'hFF -> no register changes, frame_err = 1, send_latch = 0; host write reg7 = 8'h80 -> frame_err = 0.
- Collision/reset: SPI write reg4 = AA and host write reg4 = 55 in the same clk -> reg4 = AA; reset_n pulsed mid-frame -> all registers 00, irq_n = 1, and no writes until ssel toggles high then low.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI command/data framing bridge into an 8 x 8-bit register file shared with the CoCo host port.
// Also drives the mailbox interrupt and a sticky framing-error flag.
//
// state    | meaning
// IDLE     | waiting for chip select (and a deassert seen since reset)
// CMD      | next received byte is the command byte
// WR       | data bytes are written to reg[addr_ptr]
// RD       | reg[addr_ptr] is presented on byte_send
// IGNORE   | bad command; discard bytes until chip select drops
module spi_reg_bridge #(
  parameter int         NREGS     = 8,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ssel,
  input  logic       byte_received,
  input  logic [7:0] byte_data_received,
  output logic [7:0] byte_send,
  output logic       send_latch,
  input  logic [2:0] host_addr,
  input  logic       host_we,
  input  logic       host_re,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       irq_n,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR,
    S_RD,
    S_IGNORE
  } state_t;

  state_t      state, state_next;
  logic [2:0]  ssel_s;
  logic        active;
  logic        armed;
  logic [2:0]  addr_ptr, addr_next;
  logic        ai, ai_next;
  logic        spi_we;
  logic        bad_cmd;
  logic [7:0]  regs [NREGS];

  // Synchronizer resets to "selected" so a reset taken mid-frame cannot
  // re-arm the frame decoder until a real deassert propagates through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ssel_s <= 3'b000;
      armed  <= 1'b0;
    end else begin
      ssel_s <= {ssel_s[1:0], ssel};
      if (ssel_s[2]) armed <= 1'b1;
    end
  end

  assign active = ~ssel_s[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      addr_ptr <= 3'd0;
      ai       <= 1'b0;
    end else begin
      state    <= state_next;
      addr_ptr <= addr_next;
      ai       <= ai_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = addr_ptr;
    ai_next    = ai;
    spi_we     = 1'b0;
    bad_cmd    = 1'b0;
    if (!active) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (armed) state_next = S_CMD;
        S_CMD: begin
          if (byte_received) begin
            if (byte_data_received[5:3] != 3'b000) begin
              state_next = S_IGNORE;
              bad_cmd    = 1'b1;
            end else begin
              addr_next  = byte_data_received[2:0];
              ai_next    = byte_data_received[6];
              state_next = byte_data_received[7] ? S_RD : S_WR;
            end
          end
        end
        S_WR: begin
          if (byte_received) begin
            spi_we = 1'b1;
            if (ai) addr_next = addr_ptr + 3'd1;
          end
        end
        S_RD: if (byte_received && ai) addr_next = addr_ptr + 3'd1;
        default: ;
      endcase
    end
  end

  assign send_latch = active && (state == S_RD);
  assign host_rdata = regs[host_addr];

  // SPI write takes priority over a host write to the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (spi_we && addr_ptr == 3'(i))
          regs[i] <= byte_data_received;
        else if (host_we && host_addr == 3'(i))
          regs[i] <= host_wdata;
      end
    end
  end

  // Loaded from the next pointer so the response is ready one clk after the byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      byte_send <= 8'h00;
    else if (state_next == S_RD)
      byte_send <= regs[addr_next];
    else
      byte_send <= 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_n     <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      if (spi_we && addr_ptr == 3'd0)
        irq_n <= 1'b0;
      else if (host_re && host_addr == 3'd0)
        irq_n <= 1'b1;
      if (bad_cmd)
        frame_err <= 1'b1;
      else if (host_we && host_addr == 3'd7 && host_wdata[7])
        frame_err <= 1'b0;
    end
  end

endmodule
